// File: rtl/twos_decode_serial.sv
// twos_decode_serial: bit-serial two's-complement to sign-magnitude decoder.
// Accepts one WIDTH-bit word over in_valid/in_ready and resolves the
// magnitude LSB-first with one carry bit per cycle. It then presents
// out_sign/out_mag over out_valid/out_ready. The output appears WIDTH cycles
// after the word is accepted.
// Optional feature: define TWOS_DECODE_OVF_EN to add out_ovf. out_ovf flags a
// most-negative input, whose magnitude needs all WIDTH bits.
module twos_decode_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             busy
`ifdef TWOS_DECODE_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic             carry;
  logic [CW-1:0]    count;
  logic             t_bit;
  logic             mag_bit;
  logic             last_bit;

  // The per-bit arithmetic: conditionally invert the bit, then add the carry.
  // A positive word starts with carry=0, so its bits pass through unchanged.
  always_comb begin
    t_bit    = shreg[0] ^ out_sign;
    mag_bit  = t_bit ^ carry;
    last_bit = (count == CW'(WIDTH - 1));
  end

  // The handshake outputs are decoded directly from the state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CONV);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic for the accept / convert / present sequence.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = CONV;
      CONV:    if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, then shift one magnitude bit in per CONV cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      carry    <= 1'b0;
      count    <= '0;
      out_sign <= 1'b0;
      out_mag  <= '0;
`ifdef TWOS_DECODE_OVF_EN
      out_ovf  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= in_data;
            out_sign <= in_data[WIDTH-1];
            carry    <= in_data[WIDTH-1];
            count    <= '0;
`ifdef TWOS_DECODE_OVF_EN
            out_ovf  <= 1'b0;
`endif
          end
        end
        CONV: begin
          out_mag <= {mag_bit, out_mag[WIDTH-1:1]};
          carry   <= t_bit & carry;
          shreg   <= shreg >> 1;
          count   <= count + 1'b1;
`ifdef TWOS_DECODE_OVF_EN
          // The final bit is the magnitude MSB. It can be 1 only for -2^(WIDTH-1).
          if (last_bit) out_ovf <= mag_bit;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
